// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage; writes HI/LO WIDTH+2 cycles after start.
// Ports: clk/reset (sync, active-high), start/op/src_a/src_b request, flush abort;
//        stall while busy, done + hilo_we pulse with hi_out/lo_out held until the next done.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [1:0]       hilo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;   // negate product (MUL) or quotient (DIV)
  logic                 neg_hi_q, neg_hi_d;   // negate remainder (DIV only)
  logic [WIDTH-1:0]     opb_q, opb_d;         // multiplicand magnitude or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;         // MUL: {partial, multiplier}; DIV: {remainder, quotient}
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift, div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   mul_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Operand conditioning and one iteration step of each algorithm.
  always_comb begin
    sgn_op = ~op[0];
    a_neg  = sgn_op & src_a[WIDTH-1];
    b_neg  = sgn_op & src_b[WIDTH-1];
    a_mag  = a_neg ? -src_a : src_a;
    b_mag  = b_neg ? -src_b : src_b;

    // Shift-add: conditionally add multiplicand into the upper half, then shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: bring down the next dividend bit, subtract if it fits.
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opb_q};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    mul_fix = neg_lo_q ? -acc_q : acc_q;
    quo_fix = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d  = CALC;
          cnt_d    = '0;
          is_div_d = op[1];
          if (op[1]) begin
            opb_d    = b_mag;
            acc_d    = {{WIDTH{1'b0}}, a_mag};
            // A zero divisor naturally yields quotient all-ones and remainder |a|;
            // suppressing the quotient fix keeps LO all-ones, the remainder fix restores a.
            neg_lo_d = (a_neg ^ b_neg) & (src_b != '0);
            neg_hi_d = a_neg;
          end else begin
            opb_d    = a_mag;
            acc_d    = {{WIDTH{1'b0}}, b_mag};
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = 1'b0;
          end
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = mul_fix[2*WIDTH-1:WIDTH];
          lo_d = mul_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush aborts anything in flight, including the result write in FIX.
    if (flush && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign stall   = (state_q != IDLE);
  assign done    = done_q;
  assign hilo_we = {2{done_q}};
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit: latency, signed/unsigned results, div-by-zero,
// flush (mid-op, in FIX, with start in IDLE), ignored second start and mid-op reset.
module tb_mul_div_unit;
  localparam int W = 32;
  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         stall, done;
  logic [1:0]   hilo_we;
  logic [W-1:0] hi_out, lo_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .stall(stall), .done(done), .hilo_we(hilo_we),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive start during one cycle (T); returns just after edge T.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // lat = cycle offset from T at which done is seen; stall_ok = stall high before, low at done.
  task automatic wait_done(output int lat, output bit stall_ok);
    lat = -1;
    stall_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        if (stall) stall_ok = 1'b0;
        break;
      end
      if (!stall) stall_ok = 1'b0;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int lat;
    bit ok;
    issue(o, a, b);
    wait_done(lat, ok);
    check({tag, "_lat"}, 64'(lat), 64'd34);
    check({tag, "_stall"}, 64'(ok), 64'd1);
    check({tag, "_we"}, 64'(hilo_we), 64'd3);
    check({tag, "_hi"}, 64'(hi_out), 64'(ehi));
    check({tag, "_lo"}, 64'(lo_out), 64'(elo));
  endtask

  initial begin
    int  lat;
    bit  seen;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_we", 64'(hilo_we), 64'd0);
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);
    reset = 1'b0;

    run("mult_neg",  MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE);
    run("multu",     MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE);
    run("mult_nn",   MULT,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006);
    run("div_neg",   DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divu",      DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
    run("divu_z",    DIVU,  32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF);
    run("div_z_neg", DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run("div_ovf",   DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Second start at T+5 must be ignored: the first op's result appears, no follow-on op.
    issue(MULTU, 32'd3, 32'd5);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 5) begin
        start = 1'b1; op = DIVU; src_a = 32'd100; src_b = 32'd7;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check("ign_lat", 64'(lat), 64'd34);
    check("ign_hi", 64'(hi_out), 64'd0);
    check("ign_lo", 64'(lo_out), 64'd15);
    @(negedge clk);
    check("ign_idle", 64'(stall), 64'd0);

    // Flush at T+10: idle at T+11, no done, HI/LO keep 0/15.
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    seen = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 11) check("fl_stall", 64'(stall), 64'd0);
      flush = (k == 10);
      if (done) seen = 1'b1;
    end
    flush = 1'b0;
    check("fl_done", 64'(seen), 64'd0);
    check("fl_hi", 64'(hi_out), 64'd0);
    check("fl_lo", 64'(lo_out), 64'd15);

    // Flush during FIX (cycle T+33) discards the result.
    issue(DIVU, 32'd100, 32'd7);
    seen = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 33) check("fix_stall", 64'(stall), 64'd1);
      if (k == 34) check("fix_idle", 64'(stall), 64'd0);
      flush = (k == 33);
      if (done) seen = 1'b1;
    end
    flush = 1'b0;
    check("fix_done", 64'(seen), 64'd0);
    check("fix_lo", 64'(lo_out), 64'd15);

    // start together with flush in IDLE is rejected.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MULT; src_a = 32'd2; src_b = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("sf_stall", 64'(stall), 64'd0);

    // Reset at T+20 clears everything; a new op then completes normally.
    issue(MULT, 32'd7, 32'd9);
    for (int k = 1; k <= 20; k++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mr_stall", 64'(stall), 64'd0);
    check("mr_done", 64'(done), 64'd0);
    check("mr_we", 64'(hilo_we), 64'd0);
    check("mr_hi", 64'(hi_out), 64'd0);
    check("mr_lo", 64'(lo_out), 64'd0);
    run("post_rst", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
